// File: rtl/rat_pkg.sv
// Shared definitions for the rational-arithmetic stages: reducer FSM states,
// default datapath width and the width helper for the shared power-of-two count.
package rat_pkg;

  localparam int RAT_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRIP,
    ST_GCD,
    ST_DIV,
    ST_DONE
  } rat_reduce_state_t;

  // Bits needed to count the common factors of two stripped before the GCD loop.
  function automatic int rat_clog2_k(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/rat_divu.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses for one
// cycle WIDTH cycles after start. Reusable by any rational stage.
module rat_divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // rem_q < div_q always holds, so a successful subtract fits back in WIDTH bits.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        div_q  <= divisor;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces an unsigned numerator/denominator pair to lowest terms using a binary
// GCD loop followed by two parallel dividers. valid/ready handshake on both sides.
import rat_pkg::*;

module rat_reduce #(
  parameter int WIDTH = RAT_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_num,
  input  logic [WIDTH-1:0]  in_den,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_num,
  output logic [WIDTH-1:0]  out_den,
  output logic              out_err,
  output rat_reduce_state_t dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready and results hold until accepted.

  localparam int KW = rat_clog2_k(WIDTH);

  rat_reduce_state_t state_q, state_d;
  logic [WIDTH-1:0]  n_q, n_d, d_q, d_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  out_num_q, out_num_d, out_den_q, out_den_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q;
  logic [WIDTH-1:0]  g_w;
  logic              div_start;
  logic [WIDTH-1:0]  quo_n, quo_d, rem_n, rem_d;
  logic              done_n, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      out_num_q   <= '0;
      out_den_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      out_num_q   <= out_num_d;
      out_den_q   <= out_den_d;
      out_err_q   <= out_err_d;
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // The dividers load on the same edge the FSM enters DIV, so g feeds them directly.
  assign g_w       = (a_q | b_q) << k_q;
  assign div_start = (state_q == ST_GCD) && ((a_q == '0) || (b_q == '0));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    out_num_d = out_num_q;
    out_den_d = out_den_q;
    out_err_d = out_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          n_d = in_num;
          d_d = in_den;
          a_d = in_num;
          b_d = in_den;
          k_d = '0;
          if (in_den == '0) begin
            out_num_d = in_num;
            out_den_d = '0;
            out_err_d = 1'b1;
            state_d   = ST_DONE;
          end else if (in_num == '0) begin
            out_num_d = '0;
            out_den_d = WIDTH'(1);
            out_err_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_STRIP;
          end
        end
      end
      ST_STRIP: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = ST_GCD;
        end
      end
      ST_GCD: begin
        if ((a_q == '0) || (b_q == '0)) state_d = ST_DIV;
        else if (!a_q[0])               a_d = a_q >> 1;
        else if (!b_q[0])               b_d = b_q >> 1;
        else if (a_q >= b_q)            a_d = (a_q - b_q) >> 1;
        else                            b_d = (b_q - a_q) >> 1;
      end
      ST_DIV: begin
        if (done_n && done_d) begin
          out_num_d = quo_n;
          out_den_d = quo_d;
          out_err_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  rat_divu #(.WIDTH(WIDTH)) u_div_num (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (n_q),
    .divisor  (g_w),
    .quotient (quo_n),
    .remainder(rem_n),
    .done     (done_n)
  );

  rat_divu #(.WIDTH(WIDTH)) u_div_den (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (d_q),
    .divisor  (g_w),
    .quotient (quo_d),
    .remainder(rem_d),
    .done     (done_d)
  );

  // g divides both terms, so any remainder means the GCD loop is broken.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_DIV && done_n && done_d)
      assert ((rem_n == '0) && (rem_d == '0));
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_den   = out_den_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

endmodule
